// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C command and phase encodings
package i2c_pkg;

  // Bit-level commands issued by the master byte FSM
  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_BIT   = 2'd2
  } BitCmd;

  // Quarter-period phases of one bit-engine operation
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4
  } BitPhase;

endpackage

// File: rtl/i2c_bus_monitor.sv
// rtl/i2c_bus_monitor.sv - START/STOP detector producing line_busy
module i2c_bus_monitor (
  input  logic clk,
  input  logic rst,
  input  logic sda,
  input  logic scl,
  output logic line_busy
);

  logic sda_prev;
  logic start_det;
  logic stop_det;

  // SDA edges while SCL is high are bus conditions, not data
  assign start_det = sda_prev & ~sda & scl;
  assign stop_det  = ~sda_prev & sda & scl;

  // Track previous SDA and hold busy from START until STOP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_prev  <= 1'b1;
      line_busy <= 1'b0;
    end else begin
      sda_prev <= sda;
      if (start_det) begin
        line_busy <= 1'b1;
      end else if (stop_det) begin
        line_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/i2c_bit_engine.sv
// rtl/i2c_bit_engine.sv - I2C master SCL/SDA bit engine with stretch and arbitration
module i2c_bit_engine
  import i2c_pkg::*;
#(
  parameter int DIV_WIDTH     = 32,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [DIV_WIDTH-1:0]     clk_divider,
  input  logic                     en_clock_stretch,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_limit,
  input  logic [1:0]               cmd,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     bit_in,
  input  logic                     SDA_sync,
  input  logic                     SCL_sync,
  output logic                     SDA_out,
  output logic                     SCL_out,
  output logic                     bit_out,
  output logic                     done,
  output logic                     arb_lost,
  output logic                     stretch_timeout,
  output logic                     line_busy,
  output logic                     bus_owner
);

  BitPhase                  phase;
  logic [DIV_WIDTH-1:0]     qcnt;
  logic [TIMEOUT_WIDTH-1:0] scnt;
  logic [1:0]               cmd_q;
  logic                     bit_q;
  logic                     ready_q;

  // ready_q lags phase by a cycle so ready rises the cycle after done/abort
  assign cmd_ready = ready_q & enable;

  i2c_bus_monitor u_bus_monitor (
    .clk       (clk),
    .rst       (rst),
    .sda       (SDA_sync),
    .scl       (SCL_sync),
    .line_busy (line_busy)
  );

  // Phase sequencer: drives the lines on each phase entry and raises the result pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase           <= IDLE;
      qcnt            <= '0;
      scnt            <= '0;
      cmd_q           <= CMD_BIT;
      bit_q           <= 1'b1;
      ready_q         <= 1'b0;
      SDA_out         <= 1'b1;
      SCL_out         <= 1'b1;
      bit_out         <= 1'b0;
      done            <= 1'b0;
      arb_lost        <= 1'b0;
      stretch_timeout <= 1'b0;
      bus_owner       <= 1'b0;
    end else begin
      done            <= 1'b0;
      arb_lost        <= 1'b0;
      stretch_timeout <= 1'b0;
      ready_q         <= enable && (phase == IDLE);
      if (!enable) begin
        // Disable wins over everything, including a completion this cycle
        phase     <= IDLE;
        SDA_out   <= 1'b1;
        SCL_out   <= 1'b1;
        bus_owner <= 1'b0;
        ready_q   <= 1'b0;
      end else begin
        case (phase)
          IDLE: begin
            if (cmd_valid && cmd_ready) begin
              ready_q <= 1'b0;
              if (cmd == CMD_START && line_busy && !bus_owner) begin
                // Another master owns the bus: refuse without touching the lines
                arb_lost <= 1'b1;
              end else begin
                cmd_q <= cmd;
                bit_q <= bit_in;
                phase <= P0;
                qcnt  <= clk_divider;
                case (cmd)
                  CMD_START: SDA_out <= 1'b1;
                  CMD_STOP: begin
                    SCL_out <= 1'b0;
                    SDA_out <= 1'b0;
                  end
                  default: begin
                    SCL_out <= 1'b0;
                    SDA_out <= bit_in;
                  end
                endcase
              end
            end
          end
          P0: begin
            if (qcnt == '0) begin
              phase   <= P1;
              qcnt    <= clk_divider;
              scnt    <= '0;
              SCL_out <= 1'b1;
            end else begin
              qcnt <= qcnt - DIV_WIDTH'(1);
            end
          end
          P1: begin
            if (en_clock_stretch && !SCL_sync) begin
              // Slave holds SCL low: freeze the quarter counter and count the wait
              if (timeout_limit != '0 && scnt == timeout_limit - TIMEOUT_WIDTH'(1)) begin
                stretch_timeout <= 1'b1;
                SDA_out         <= 1'b1;
                SCL_out         <= 1'b1;
                bus_owner       <= 1'b0;
                phase           <= IDLE;
              end else begin
                scnt <= scnt + TIMEOUT_WIDTH'(1);
              end
            end else if (qcnt == '0) begin
              phase <= P2;
              qcnt  <= clk_divider;
              if (cmd_q == CMD_START) begin
                SDA_out <= 1'b0;
              end else if (cmd_q == CMD_STOP) begin
                SDA_out <= 1'b1;
              end
            end else begin
              qcnt <= qcnt - DIV_WIDTH'(1);
            end
          end
          P2: begin
            if (qcnt == '0) begin
              if (cmd_q == CMD_BIT) begin
                bit_out <= SDA_sync;
              end
              if (cmd_q == CMD_BIT && bit_q && !SDA_sync) begin
                // Released SDA reads low: someone else is driving, back off at once
                arb_lost  <= 1'b1;
                SDA_out   <= 1'b1;
                SCL_out   <= 1'b1;
                bus_owner <= 1'b0;
                phase     <= IDLE;
              end else begin
                phase <= P3;
                qcnt  <= clk_divider;
                if (cmd_q == CMD_STOP) begin
                  SDA_out <= 1'b1;
                  SCL_out <= 1'b1;
                end else begin
                  SCL_out <= 1'b0;
                end
              end
            end else begin
              qcnt <= qcnt - DIV_WIDTH'(1);
            end
          end
          P3: begin
            if (qcnt == '0) begin
              phase <= IDLE;
              done  <= 1'b1;
              if (cmd_q == CMD_START) begin
                bus_owner <= 1'b1;
              end else if (cmd_q == CMD_STOP) begin
                bus_owner <= 1'b0;
              end
            end else begin
              qcnt <= qcnt - DIV_WIDTH'(1);
            end
          end
          default: phase <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_bit_engine.sv
// tb/tb_i2c_bit_engine.sv - directed self-checking bench for i2c_bit_engine
module tb_i2c_bit_engine;
  import i2c_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] clk_divider;
  logic        en_clock_stretch;
  logic [15:0] timeout_limit;
  logic [1:0]  cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        bit_in;
  logic        SDA_sync;
  logic        SCL_sync;
  logic        SDA_out;
  logic        SCL_out;
  logic        bit_out;
  logic        done;
  logic        arb_lost;
  logic        stretch_timeout;
  logic        line_busy;
  logic        bus_owner;

  logic slave_hold;
  logic sda_force_low;

  int n_checks;
  int n_errors;
  int done_at, arb_at, to_at, sda_fall, scl_fall, n_pulses;

  // Wired-AND bus: the line is low if anyone pulls it low
  assign SCL_sync = SCL_out & ~slave_hold;
  assign SDA_sync = SDA_out & ~sda_force_low;

  always #5 clk = ~clk;

  i2c_bit_engine #(.DIV_WIDTH(32), .TIMEOUT_WIDTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .clk_divider      (clk_divider),
    .en_clock_stretch (en_clock_stretch),
    .timeout_limit    (timeout_limit),
    .cmd              (cmd),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .bit_in           (bit_in),
    .SDA_sync         (SDA_sync),
    .SCL_sync         (SCL_sync),
    .SDA_out          (SDA_out),
    .SCL_out          (SCL_out),
    .bit_out          (bit_out),
    .done             (done),
    .arb_lost         (arb_lost),
    .stretch_timeout  (stretch_timeout),
    .line_busy        (line_busy),
    .bus_owner        (bus_owner)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] c, input logic b);
    cmd       = c;
    bit_in    = b;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Step up to max_cyc cycles after acceptance, logging event cycles (acceptance edge = 0)
  task automatic run(input int max_cyc, input int hold_until, input bit stop_at_end);
    logic sda_p, scl_p;
    sda_p = SDA_out;
    scl_p = SCL_out;
    done_at = -1; arb_at = -1; to_at = -1; sda_fall = -1; scl_fall = -1; n_pulses = 0;
    for (int n = 1; n <= max_cyc; n++) begin
      tick();
      if (n == hold_until) slave_hold = 1'b0;
      if (done) begin if (done_at < 0) done_at = n; n_pulses++; end
      if (arb_lost) begin if (arb_at < 0) arb_at = n; n_pulses++; end
      if (stretch_timeout) begin if (to_at < 0) to_at = n; n_pulses++; end
      if (sda_p && !SDA_out && sda_fall < 0) sda_fall = n;
      if (scl_p && !SCL_out && scl_fall < 0) scl_fall = n;
      sda_p = SDA_out;
      scl_p = SCL_out;
      if (stop_at_end && (done || arb_lost || stretch_timeout)) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; clk_divider = 32'd3; en_clock_stretch = 1'b0;
    timeout_limit = 16'd0; cmd = CMD_BIT; cmd_valid = 1'b0; bit_in = 1'b0;
    slave_hold = 1'b0; sda_force_low = 1'b0; n_checks = 0; n_errors = 0;
    tick(); tick();
    check("rst_sda", SDA_out, 1);
    check("rst_scl", SCL_out, 1);
    check("rst_ready", cmd_ready, 0);
    check("rst_done", done, 0);
    check("rst_owner", bus_owner, 0);
    check("rst_busy", line_busy, 0);
    check("rst_bit_out", bit_out, 0);
    rst = 1'b0;
    check("ready_before_edge", cmd_ready, 0);
    tick();
    check("ready_after_rst", cmd_ready, 1);

    issue(CMD_START, 1'b0);
    check("start_ready_drop", cmd_ready, 0);
    run(40, 0, 1);
    check("start_sda_fall", sda_fall, 8);
    check("start_scl_fall", scl_fall, 12);
    check("start_done", done_at, 16);
    check("start_busy", line_busy, 1);
    check("start_owner", bus_owner, 1);
    tick();
    check("start_ready_back", cmd_ready, 1);

    issue(CMD_BIT, 1'b0);
    run(40, 0, 1);
    check("bit0_done", done_at, 16);
    check("bit0_out", bit_out, 0);
    check("bit0_ready_at_done", cmd_ready, 0);
    tick();
    check("bit0_ready_back", cmd_ready, 1);

    en_clock_stretch = 1'b1;
    slave_hold = 1'b1;
    issue(CMD_BIT, 1'b1);
    run(60, 24, 1);
    check("stretch20_done", done_at, 36);
    check("stretch20_bit_out", bit_out, 1);
    tick();

    timeout_limit = 16'd50;
    slave_hold = 1'b1;
    issue(CMD_BIT, 1'b1);
    run(110, 104, 0);
    check("timeout_at", to_at, 54);
    check("timeout_pulses", n_pulses, 1);
    check("timeout_no_done", done_at, -1);
    check("timeout_sda", SDA_out, 1);
    check("timeout_scl", SCL_out, 1);
    check("timeout_owner", bus_owner, 0);

    timeout_limit = 16'd0;
    en_clock_stretch = 1'b0;
    sda_force_low = 1'b1;
    issue(CMD_BIT, 1'b1);
    run(40, 0, 1);
    check("arb_bit_at", arb_at, 12);
    check("arb_bit_no_done", done_at, -1);
    check("arb_bit_sda", SDA_out, 1);
    check("arb_bit_scl", SCL_out, 1);
    check("arb_bit_ready_at", cmd_ready, 0);
    tick();
    check("arb_bit_ready_next", cmd_ready, 1);
    sda_force_low = 1'b0;
    tick();
    check("ext_stop_clears_busy", line_busy, 0);

    sda_force_low = 1'b1;
    tick();
    check("ext_start_busy", line_busy, 1);
    issue(CMD_START, 1'b0);
    check("arb_start_pulse", arb_lost, 1);
    check("arb_start_sda", SDA_out, 1);
    check("arb_start_scl", SCL_out, 1);
    tick();
    check("arb_start_single", arb_lost, 0);
    check("arb_start_ready", cmd_ready, 1);
    sda_force_low = 1'b0;
    tick();
    check("ext_stop_busy", line_busy, 0);
    issue(CMD_START, 1'b0);
    run(40, 0, 1);
    check("retry_start_done", done_at, 16);
    check("retry_start_owner", bus_owner, 1);
    tick();

    issue(CMD_STOP, 1'b0);
    run(9, 0, 0);
    check("stop_pre_pulses", n_pulses, 0);
    enable = 1'b0;
    tick();
    check("abort_sda", SDA_out, 1);
    check("abort_scl", SCL_out, 1);
    check("abort_owner", bus_owner, 0);
    check("abort_ready", cmd_ready, 0);
    run(20, 0, 0);
    check("abort_no_pulses", n_pulses, 0);
    check("abort_busy", line_busy, 0);
    enable = 1'b1;
    tick();
    check("abort_ready_back", cmd_ready, 1);

    issue(CMD_BIT, 1'b0);
    run(6, 0, 0);
    check("rstmid_pulses", n_pulses, 0);
    check("rstmid_sda_low", SDA_out, 0);
    rst = 1'b1;
    #1;
    check("rstmid_sda", SDA_out, 1);
    check("rstmid_scl", SCL_out, 1);
    check("rstmid_ready", cmd_ready, 0);
    check("rstmid_done", done, 0);
    check("rstmid_arb", arb_lost, 0);
    check("rstmid_to", stretch_timeout, 0);
    tick();
    rst = 1'b0;
    tick();
    check("rstmid_ready_back", cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
